// File: rtl/gauss_pkg.sv
// ============================================================================
// Module      : gauss_pkg
// Description : Shared constants, FSM state type and helpers for the 5-tap
//               Gaussian row filter sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gauss_pkg;

  localparam int WIDTH      = 640;
  localparam int COL_W      = 13;
  localparam int NORM_SHIFT = 4;
  localparam int N_TAPS     = 5;
  localparam int PIX_W      = 8;
  localparam int ACC_W      = 19;
  localparam int TAP_W      = 3;
  localparam int COEF_W     = N_TAPS * PIX_W;
  localparam int COLX_W     = COL_W + 1;

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(WIDTH - 1);
  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(N_TAPS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Source column for a tap: c + tap - 2, clamped so edge pixels are replicated.
  function automatic logic [COL_W-1:0] clamp_col(input logic [COL_W-1:0] col,
                                                 input logic [TAP_W-1:0] tap);
    logic [COLX_W-1:0] pos;
    logic [COLX_W-1:0] off;
    pos = {1'b0, col} + {{(COLX_W - TAP_W){1'b0}}, tap};
    off = pos - COLX_W'(2);
    if (pos < COLX_W'(2)) begin
      clamp_col = '0;
    end else if (off > {1'b0, LAST_COL}) begin
      clamp_col = LAST_COL;
    end else begin
      clamp_col = off[COL_W-1:0];
    end
  endfunction

  function automatic logic [PIX_W-1:0] coef_sel(input logic [COEF_W-1:0] coefs,
                                                input logic [TAP_W-1:0]  tap);
    case (tap)
      3'd0:    coef_sel = coefs[7:0];
      3'd1:    coef_sel = coefs[15:8];
      3'd2:    coef_sel = coefs[23:16];
      3'd3:    coef_sel = coefs[31:24];
      3'd4:    coef_sel = coefs[39:32];
      default: coef_sel = '0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/gauss_row_seq_if.sv
// ============================================================================
// Module      : gauss_row_seq_if
// Description : Control, line-buffer read and filtered-row write signals of
//               the Gaussian row sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface gauss_row_seq_if;
  import gauss_pkg::*;

  logic               start;
  logic               en_gauss;
  logic [COEF_W-1:0]  gauss_coef;
  logic [COL_W-1:0]   rd_col;
  logic [PIX_W-1:0]   pix_in;
  logic               wr_en;
  logic [COL_W-1:0]   wr_col;
  logic [PIX_W-1:0]   wr_data;
  logic               busy;
  logic               done;

  modport master (
    input  start, en_gauss, gauss_coef, pix_in,
    output rd_col, wr_en, wr_col, wr_data, busy, done
  );

  modport slave (
    output start, en_gauss, gauss_coef, pix_in,
    input  rd_col, wr_en, wr_col, wr_data, busy, done
  );

endinterface

`default_nettype wire

// File: rtl/gauss_mac.sv
// ============================================================================
// Module      : gauss_mac
// Description : Tap multiplier, 19-bit load/accumulate register, normalising
//               shift and 8-bit saturation for the Gaussian row filter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gauss_mac
  import gauss_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              vld,
  input  logic [TAP_W-1:0]  tap,
  input  logic [PIX_W-1:0]  pix,
  input  logic [COEF_W-1:0] coefs,
  output logic [PIX_W-1:0]  sat_data
);

  logic [ACC_W-1:0]     acc_q;
  logic [ACC_W-1:0]     acc_d;
  logic [ACC_W-1:0]     norm;
  logic [2*PIX_W-1:0]   prod;
  logic [PIX_W-1:0]     coef;

  // sat_data reflects the accumulator value being written this cycle, so the
  // tap-4 result is available to register in the same edge as the accumulate.
  always_comb begin
    coef  = coef_sel(coefs, tap);
    prod  = {{PIX_W{1'b0}}, pix} * {{PIX_W{1'b0}}, coef};
    acc_d = acc_q;
    if (vld) begin
      if (tap == '0) begin
        acc_d = {{(ACC_W - 2*PIX_W){1'b0}}, prod};
      end else begin
        acc_d = acc_q + {{(ACC_W - 2*PIX_W){1'b0}}, prod};
      end
    end
    norm = acc_d >> NORM_SHIFT;
    if (norm > ACC_W'(255)) begin
      sat_data = '1;
    end else begin
      sat_data = norm[PIX_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/gauss_row_seq.sv
// ============================================================================
// Module      : gauss_row_seq
// Description : Row sequencer for the 5-tap Gaussian filter: issues clamped
//               tap reads, drives the MAC and writes one byte per column.
//               Optional build macro GAUSS_BYPASS_EN adds a pass-through mode
//               selected by en_gauss=0 at start.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gauss_row_seq
  import gauss_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  gauss_row_seq_if.master bus
);

  state_t             state_q, state_d;
  logic [TAP_W-1:0]   tap_q, tap_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic               drain_q, drain_d;
  logic               byp_q, byp_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               vld_q, vld_d;
  logic [TAP_W-1:0]   tap_dly_q, tap_dly_d;
  logic [COL_W-1:0]   col_dly_q, col_dly_d;

  logic               wr_en_q, wr_en_d;
  logic [COL_W-1:0]   wr_col_q, wr_col_d;
  logic [PIX_W-1:0]   wr_data_q, wr_data_d;

  logic               issue;
  logic               byp_wr;
  logic               mac_vld;
  logic               mac_last;
  logic [PIX_W-1:0]   mac_data;

`ifndef GAUSS_BYPASS_EN
  logic unused_en_gauss;
  assign unused_en_gauss = bus.en_gauss;
`endif

  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    col_d   = col_q;
    drain_d = drain_q;
    byp_d   = byp_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          tap_d   = '0;
          col_d   = '0;
`ifdef GAUSS_BYPASS_EN
          byp_d   = ~bus.en_gauss;
`else
          byp_d   = 1'b0;
`endif
        end
      end
      RUN: begin
        if (byp_q || tap_q == LAST_TAP) begin
          tap_d = '0;
          if (col_q == LAST_COL) begin
            state_d = DRAIN;
            col_d   = '0;
            // Bypass has a single-cycle pipeline, so it needs one drain cycle.
            drain_d = byp_q;
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end else begin
          tap_d = tap_q + TAP_W'(1);
        end
      end
      DRAIN: begin
        if (drain_q) begin
          state_d = DONE;
          drain_d = 1'b0;
        end else begin
          drain_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        byp_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_comb begin
    issue     = (state_q == RUN);
    vld_d     = issue;
    tap_dly_d = tap_q;
    col_dly_d = col_q;
    byp_wr    = byp_q & vld_q;
    mac_vld   = vld_q & ~byp_q;
    mac_last  = mac_vld & (tap_dly_q == LAST_TAP);
    wr_en_d   = mac_last;
    wr_col_d  = wr_col_q;
    wr_data_d = wr_data_q;
    if (mac_last || byp_wr) begin
      wr_col_d = col_dly_q;
    end
    if (mac_last) begin
      wr_data_d = mac_data;
    end else if (byp_wr) begin
      wr_data_d = bus.pix_in;
    end
  end

  assign bus.rd_col  = issue ? (byp_q ? col_q : clamp_col(col_q, tap_q)) : '0;
  assign bus.wr_en   = wr_en_q | byp_wr;
  assign bus.wr_col  = byp_wr ? col_dly_q : wr_col_q;
  assign bus.wr_data = byp_wr ? bus.pix_in : wr_data_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      tap_q     <= '0;
      col_q     <= '0;
      drain_q   <= 1'b0;
      byp_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      vld_q     <= 1'b0;
      tap_dly_q <= '0;
      col_dly_q <= '0;
      wr_en_q   <= 1'b0;
      wr_col_q  <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      tap_q     <= tap_d;
      col_q     <= col_d;
      drain_q   <= drain_d;
      byp_q     <= byp_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      vld_q     <= vld_d;
      tap_dly_q <= tap_dly_d;
      col_dly_q <= col_dly_d;
      wr_en_q   <= wr_en_d;
      wr_col_q  <= wr_col_d;
      wr_data_q <= wr_data_d;
    end
  end

  gauss_mac u_mac (
    .clk      (clk),
    .rst      (rst),
    .vld      (mac_vld),
    .tap      (tap_dly_q),
    .pix      (bus.pix_in),
    .coefs    (bus.gauss_coef),
    .sat_data (mac_data)
  );

endmodule

`default_nettype wire

// File: tb/tb_gauss_row_seq.sv
// ============================================================================
// Module      : tb_gauss_row_seq
// Description : Self-checking bench for gauss_row_seq against a per-column
//               arithmetic model of the 5-tap clamped Gaussian row filter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gauss_row_seq;
  import gauss_pkg::*;

  localparam int LOG_N  = 16384;
  localparam int HIST_N = 65536;
  localparam logic [39:0] BINOM = 40'h01_04_06_04_01;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gauss_row_seq_if bus ();

  gauss_row_seq u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] mem [WIDTH];
  always @(posedge clk) bus.pix_in <= mem[bus.rd_col];

  int n_total = 0;
  int n_bad   = 0;

  // Output monitor: counts negedges and logs every write and done pulse.
  int neg_count = 0;
  int wr_total  = 0;
  int done_cnt  = 0;
  int last_done = 0;
  logic [COL_W-1:0] log_col [LOG_N];
  logic [7:0]       log_dat [LOG_N];
  int               log_cyc [LOG_N];
  logic [COL_W-1:0] rd_hist [HIST_N];

  always @(negedge clk) begin : mon
    int now;
    now = neg_count + 1;
    neg_count <= now;
    if (now < HIST_N) rd_hist[now] <= bus.rd_col;
    if (bus.wr_en === 1'b1) begin
      if (wr_total < LOG_N) begin
        log_col[wr_total] <= bus.wr_col;
        log_dat[wr_total] <= bus.wr_data;
        log_cyc[wr_total] <= now;
      end
      wr_total <= wr_total + 1;
    end
    if (bus.done === 1'b1) begin
      done_cnt  <= done_cnt + 1;
      last_done <= now;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic int src_col(int c, int j);
    int s;
    s = c + j - 2;
    if (s < 0) s = 0;
    if (s > WIDTH - 1) s = WIDTH - 1;
    return s;
  endfunction

  function automatic int model_pix(int c, logic [39:0] k);
    int sum;
    sum = 0;
    for (int j = 0; j < N_TAPS; j++) sum += int'(k[8*j +: 8]) * int'(mem[src_col(c, j)]);
    sum = sum / (1 << NORM_SHIFT);
    return (sum > 255) ? 255 : sum;
  endfunction

  task automatic run_row(input string name, input logic [39:0] k, input logic en, input int mid_start);
    int base, dbase, t0, cnt, waited;
    bit byp;
    int exp_v [WIDTH];
    byp = 1'b0;
`ifdef GAUSS_BYPASS_EN
    byp = !en;
`endif
    for (int c = 0; c < WIDTH; c++) exp_v[c] = byp ? int'(mem[c]) : model_pix(c, k);
    bus.gauss_coef = k;
    bus.en_gauss   = en;
    step();
    base  = wr_total;
    dbase = done_cnt;
    bus.start = 1'b1;
    t0 = neg_count;
    step();
    bus.start = 1'b0;
    waited = 0;
    while (done_cnt == dbase && waited < 5 * WIDTH + 50) begin
      bus.start = (mid_start != 0 && waited == mid_start) ? 1'b1 : 1'b0;
      step();
      waited++;
    end
    bus.start = 1'b0;
    check_val({name, " done_seen"}, done_cnt - dbase, 1);
    check_val({name, " done_cycle"}, last_done - t0, byp ? WIDTH + 2 : 5 * WIDTH + 3);
    cnt = wr_total - base;
    check_val({name, " write_count"}, cnt, WIDTH);
    for (int i = 0; i < cnt && i < WIDTH && base + i < LOG_N; i++) begin
      check_val($sformatf("%s col[%0d]", name, i), log_col[base + i], i);
      check_val($sformatf("%s data[%0d]", name, i), log_dat[base + i], exp_v[i]);
      check_val($sformatf("%s wr_cycle[%0d]", name, i), log_cyc[base + i] - t0,
                byp ? 2 + i : 7 + 5 * i);
    end
    if (!byp) begin
      for (int j = 0; j < N_TAPS; j++)
        check_val($sformatf("%s rd_col c0 t%0d", name, j), rd_hist[t0 + 1 + j], src_col(0, j));
      check_val($sformatf("%s rd_col c%0d t0", name, WIDTH - 1), rd_hist[t0 + 1 + 5 * (WIDTH - 1)],
                src_col(WIDTH - 1, 0));
    end else begin
      check_val({name, " byp rd_col c0"}, rd_hist[t0 + 1], 0);
      check_val({name, " byp rd_col c5"}, rd_hist[t0 + 6], 5);
    end
    step();
    check_val({name, " busy_after"}, bus.busy, 0);
  endtask

  task automatic reset_mid_row();
    int base, waited, snap;
    bus.gauss_coef = BINOM;
    bus.en_gauss   = 1'b1;
    step();
    base = wr_total;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    waited = 0;
    while (wr_total - base < 301 && waited < 5 * WIDTH) begin
      step();
      waited++;
    end
    check_val("rstmid reached_col300", wr_total - base, 301);
    rst = 1'b1;
    #1;
    check_val("rstmid wr_en", bus.wr_en, 0);
    check_val("rstmid wr_col", bus.wr_col, 0);
    check_val("rstmid wr_data", bus.wr_data, 0);
    check_val("rstmid busy", bus.busy, 0);
    check_val("rstmid done", bus.done, 0);
    check_val("rstmid rd_col", bus.rd_col, 0);
    step();
    snap = wr_total;
    repeat (3) step();
    rst = 1'b0;
    repeat (20) step();
    check_val("rstmid no_writes", wr_total - snap, 0);
    check_val("rstmid idle_busy", bus.busy, 0);
  endtask

  initial begin : wdog
    #1500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [39:0] k;
    bus.start      = 1'b0;
    bus.en_gauss   = 1'b1;
    bus.gauss_coef = BINOM;
    for (int c = 0; c < WIDTH; c++) mem[c] = 8'd0;
    repeat (3) step();
    check_val("reset rd_col", bus.rd_col, 0);
    check_val("reset wr_en", bus.wr_en, 0);
    check_val("reset wr_col", bus.wr_col, 0);
    check_val("reset wr_data", bus.wr_data, 0);
    check_val("reset busy", bus.busy, 0);
    check_val("reset done", bus.done, 0);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check_val("start_in_reset busy", bus.busy, 0);
    rst = 1'b0;
    repeat (2) step();

    for (int c = 0; c < WIDTH; c++) mem[c] = 8'd100;
    run_row("flat", BINOM, 1'b1, 0);

    for (int c = 0; c < WIDTH; c++) mem[c] = (c == 10) ? 8'd160 : 8'd0;
    run_row("impulse", BINOM, 1'b1, 0);

    for (int c = 0; c < WIDTH; c++) mem[c] = 8'(c);
    run_row("ramp", BINOM, 1'b1, 0);

    for (int c = 0; c < WIDTH; c++) mem[c] = 8'd255;
    run_row("saturate", 40'hFF_FF_FF_FF_FF, 1'b1, 0);

    for (int c = 0; c < WIDTH; c++) mem[c] = 8'($urandom);
    for (int j = 0; j < N_TAPS; j++) k[8*j +: 8] = 8'($urandom_range(0, 7));
    run_row("rand_small", k, 1'b1, 0);

    for (int c = 0; c < WIDTH; c++) mem[c] = 8'($urandom);
    for (int j = 0; j < N_TAPS; j++) k[8*j +: 8] = 8'($urandom);
    run_row("rand_full", k, 1'b1, 0);

    for (int c = 0; c < WIDTH; c++) mem[c] = 8'($urandom);
    run_row("mid_start", BINOM, 1'b1, 1000);

    reset_mid_row();
    run_row("after_rst", BINOM, 1'b1, 0);

    for (int c = 0; c < WIDTH; c++) mem[c] = 8'($urandom);
    run_row("en_low", BINOM, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
